// File: rtl/aud_interp_dsp.sv
// Audio playback engine: streams SRAM samples to the DAC once per LR-clock falling edge,
// with fast-forward, sample-hold slow-down and linearly interpolated slow-down.
module aud_interp_dsp #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned SPEED_W = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_pause,
    input  logic               i_stop,
    input  logic [SPEED_W-1:0] i_speed,
    input  logic               i_fast,
    input  logic               i_slow_0,
    input  logic               i_slow_1,
    input  logic               i_daclrck,
    input  logic [DATA_W-1:0]  i_sram_data,
    input  logic [ADDR_W-1:0]  i_stop_addr,
    output logic [DATA_W-1:0]  o_dac_data,
    output logic [ADDR_W-1:0]  o_sram_addr,
    output logic [1:0]         o_state,
    output logic               o_fin
);
    localparam int unsigned IW  = DATA_W + SPEED_W + 2;
    localparam int unsigned AW1 = ADDR_W + 1;
    localparam int unsigned NW  = SPEED_W + 1;

    typedef enum logic [1:0] {StIdle = 2'd0, StPlay = 2'd1, StPause = 2'd2} state_e;
    typedef enum logic [1:0] {ModeNormal, ModeFast, ModeSlow0, ModeSlow1} mode_e;

    state_e             state_q;
    mode_e              mode_q, mode;
    logic [SPEED_W-1:0] speed_q, k_q, k_eff;
    logic [ADDR_W-1:0]  addr_q, addr_inc, addr_fast;
    logic [DATA_W-1:0]  dac_q, prev_q, interp;
    logic               fin_q, lr_q, end_q;
    logic               tick, at_end, last_k, leave;
    logic [NW-1:0]      n_val;
    logic [AW1-1:0]     fast_sum;
    logic signed [IW-1:0] diff, prod, quot;
    logic               unused_quot;

    always_comb begin
        tick = lr_q & ~i_daclrck;
        mode = ModeNormal;
        if (i_fast)        mode = ModeFast;
        else if (i_slow_1) mode = ModeSlow1;
        else if (i_slow_0) mode = ModeSlow0;
        n_val  = {1'b0, i_speed} + NW'(1);
        k_eff  = (mode != mode_q || i_speed != speed_q) ? '0 : k_q;
        last_k = (k_eff == i_speed);
        at_end = (addr_q >= i_stop_addr);
        // Inclusive limit: the sample at i_stop_addr is still played; end_q marks it consumed.
        leave  = i_stop | end_q | (addr_q > i_stop_addr);
        addr_inc  = addr_q + ADDR_W'(1);
        fast_sum  = AW1'(addr_q) + AW1'(n_val);
        addr_fast = (fast_sum > AW1'(i_stop_addr)) ? i_stop_addr : fast_sum[ADDR_W-1:0];
        diff = $signed({{(IW-DATA_W){i_sram_data[DATA_W-1]}}, i_sram_data})
             - $signed({{(IW-DATA_W){prev_q[DATA_W-1]}}, prev_q});
        prod = diff * $signed({{(IW-SPEED_W){1'b0}}, k_eff});
        quot = prod / $signed({{(IW-NW){1'b0}}, n_val});
        interp = prev_q + quot[DATA_W-1:0];
        unused_quot = ^quot[IW-1:DATA_W];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            dac_q   <= '0;
            fin_q   <= 1'b0;
            k_q     <= '0;
            prev_q  <= '0;
            lr_q    <= 1'b0;
            mode_q  <= ModeNormal;
            speed_q <= '0;
            end_q   <= 1'b0;
        end else begin
            lr_q  <= i_daclrck;
            fin_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    dac_q <= '0;
                    if (i_start) begin
                        state_q <= StPlay;
                        addr_q  <= '0;
                        prev_q  <= '0;
                        k_q     <= '0;
                        end_q   <= 1'b0;
                    end
                end
                StPlay: begin
                    if (leave) begin
                        state_q <= StIdle;
                        fin_q   <= 1'b1;
                        addr_q  <= '0;
                        dac_q   <= '0;
                        end_q   <= 1'b0;
                    end else if (i_pause) begin
                        state_q <= StPause;
                        dac_q   <= '0;
                    end else if (tick) begin
                        mode_q  <= mode;
                        speed_q <= i_speed;
                        unique case (mode)
                            ModeNormal: begin
                                dac_q  <= i_sram_data;
                                prev_q <= i_sram_data;
                                k_q    <= '0;
                                if (at_end) end_q  <= 1'b1;
                                else        addr_q <= addr_inc;
                            end
                            ModeFast: begin
                                dac_q <= i_sram_data;
                                k_q   <= '0;
                                if (at_end) end_q  <= 1'b1;
                                else        addr_q <= addr_fast;
                            end
                            ModeSlow0, ModeSlow1: begin
                                dac_q <= (mode == ModeSlow1) ? interp : i_sram_data;
                                if (last_k) begin
                                    k_q <= '0;
                                    if (mode == ModeSlow1) prev_q <= i_sram_data;
                                    if (at_end) end_q  <= 1'b1;
                                    else        addr_q <= addr_inc;
                                end else begin
                                    k_q <= k_eff + SPEED_W'(1);
                                end
                            end
                        endcase
                    end
                end
                StPause: begin
                    dac_q <= '0;
                    if (i_stop) begin
                        state_q <= StIdle;
                        addr_q  <= '0;
                        end_q   <= 1'b0;
                    end else if (i_start) begin
                        state_q <= StPlay;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_dac_data  = dac_q;
    assign o_sram_addr = addr_q;
    assign o_state     = state_q;
    assign o_fin       = fin_q;
endmodule
